// File: rtl/sm_layer_par.sv
// sm_layer_par: control FSM for one fully-connected layer.
// Sequences neuron groups over N_MAC MAC lanes with memory latency compensation.
module sm_layer_par #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 16'h0000,
   parameter int                    N_IN        = 784,
   parameter int                    N_OUT       = 10,
   parameter int                    N_MAC       = 2,
   parameter int                    MEM_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  reset,
   input  logic                  relu_mode,
   output logic                  done,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] a_addr,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic                  mem_rd,
   output logic [N_MAC-1:0]      mac_clr,
   output logic [N_MAC-1:0]      mac_en,
   output logic [N_MAC-1:0]      r_sh_en,
   output logic                  act_relu
);

   localparam int G  = (N_OUT + N_MAC - 1) / N_MAC;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   localparam logic [GW-1:0] G_LAST = GW'(G - 1);
   localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
   localparam logic [LW-1:0] L_LAST = LW'(MEM_LAT - 1);

   localparam logic [ADDR_WIDTH-1:0] W_STEP = ADDR_WIDTH'(N_IN);
   localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_FETCH,
      S_DRAIN,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t state, state_d;

   logic [GW-1:0] g, g_d;
   logic [IW-1:0] i, i_d;
   logic [LW-1:0] lc, lc_d;

   logic [ADDR_WIDTH-1:0] wbase, wbase_d;
   logic [ADDR_WIDTH-1:0] a_d, w_d;

   logic busy_d, done_d, relu_d, rd_d;

   logic [N_MAC-1:0] mask_d, clr_d, sh_d, en0_d;

   // Stage 0 is aligned with mem_rd; stage MEM_LAT meets the returning data.
   logic [N_MAC-1:0] pipe [0:MEM_LAT];

   // Lane l of group gi is live only if its neuron index exists.
   function automatic logic [N_MAC-1:0] lane_mask(input logic [GW-1:0] gi);
      logic [N_MAC-1:0] m;
      m = '0;
      for (int l = 0; l < N_MAC; l++) begin
         m[l] = (int'(gi) * N_MAC + l) < N_OUT;
      end
      return m;
   endfunction

   // Next-state and next-output logic; strobes derive from the next state.
   always_comb begin
      state_d = state;
      g_d     = g;
      i_d     = i;
      lc_d    = lc;
      wbase_d = wbase;
      busy_d  = busy;
      done_d  = done;
      relu_d  = act_relu;
      rd_d    = 1'b0;
      a_d     = a_addr;
      w_d     = w_addr;
      if (reset) begin
         state_d = S_IDLE;
         g_d     = '0;
         i_d     = '0;
         lc_d    = '0;
         wbase_d = ADDR_BASE_W;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         a_d     = ADDR_BASE_A;
         w_d     = ADDR_BASE_W;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = S_CLR;
                  g_d     = '0;
                  i_d     = '0;
                  wbase_d = ADDR_BASE_W;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  relu_d  = relu_mode;
               end
            end
            S_CLR: begin
               state_d = S_FETCH;
               i_d     = '0;
               rd_d    = 1'b1;
               a_d     = ADDR_BASE_A;
               w_d     = wbase;
            end
            S_FETCH: begin
               if (i == I_LAST) begin
                  state_d = S_DRAIN;
                  lc_d    = '0;
               end else begin
                  i_d  = i + IW'(1);
                  rd_d = 1'b1;
                  a_d  = a_addr + A_ONE;
                  w_d  = w_addr + A_ONE;
               end
            end
            S_DRAIN: begin
               if (lc == L_LAST) begin
                  state_d = S_SHIFT;
               end else begin
                  lc_d = lc + LW'(1);
               end
            end
            S_SHIFT: begin
               if (g == G_LAST) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_CLR;
                  g_d     = g + GW'(1);
                  wbase_d = wbase + W_STEP;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      mask_d = lane_mask(g_d);
      clr_d  = (state_d == S_CLR) ? mask_d : '0;
      sh_d   = (state_d == S_SHIFT) ? mask_d : '0;
      en0_d  = rd_d ? mask_d : '0;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         g        <= '0;
         i        <= '0;
         lc       <= '0;
         wbase    <= ADDR_BASE_W;
         busy     <= 1'b0;
         done     <= 1'b0;
         act_relu <= 1'b0;
         mem_rd   <= 1'b0;
         a_addr   <= ADDR_BASE_A;
         w_addr   <= ADDR_BASE_W;
         mac_clr  <= '0;
         r_sh_en  <= '0;
      end else begin
         state    <= state_d;
         g        <= g_d;
         i        <= i_d;
         lc       <= lc_d;
         wbase    <= wbase_d;
         busy     <= busy_d;
         done     <= done_d;
         act_relu <= relu_d;
         mem_rd   <= rd_d;
         a_addr   <= a_d;
         w_addr   <= w_d;
         mac_clr  <= clr_d;
         r_sh_en  <= sh_d;
      end
   end

   // Read-latency pipe for the accumulate enables; soft reset flushes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k <= MEM_LAT; k++) pipe[k] <= '0;
      end else if (reset) begin
         for (int k = 0; k <= MEM_LAT; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= en0_d;
         for (int k = 1; k <= MEM_LAT; k++) pipe[k] <= pipe[k-1];
      end
   end

   assign mac_en = pipe[MEM_LAT];

endmodule

// File: tb/tb_sm_layer_par.sv
// tb_sm_layer_par: directed bench for sm_layer_par.
// Two instances: latency 1 at base 0, latency 3 at offset bases.
module tb_sm_layer_par;

   logic clk = 1'b0;
   logic rst, start, start3, reset, relu_mode;

   logic        done, busy, mem_rd, act_relu;
   logic [15:0] a_addr, w_addr;
   logic [1:0]  mac_clr, mac_en, r_sh_en;

   logic        done3, busy3, mem_rd3, act_relu3;
   logic [15:0] a_addr3, w_addr3;
   logic [1:0]  mac_clr3, mac_en3, r_sh_en3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sm_layer_par #(
      .ADDR_WIDTH(16), .ADDR_BASE_A(16'h0000), .ADDR_BASE_W(16'h0000),
      .N_IN(4), .N_OUT(5), .N_MAC(2), .MEM_LAT(1)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .reset(reset),
      .relu_mode(relu_mode), .done(done), .busy(busy),
      .a_addr(a_addr), .w_addr(w_addr), .mem_rd(mem_rd),
      .mac_clr(mac_clr), .mac_en(mac_en), .r_sh_en(r_sh_en),
      .act_relu(act_relu)
   );

   sm_layer_par #(
      .ADDR_WIDTH(16), .ADDR_BASE_A(16'h0100), .ADDR_BASE_W(16'hFFFC),
      .N_IN(4), .N_OUT(5), .N_MAC(2), .MEM_LAT(3)
   ) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .reset(reset),
      .relu_mode(relu_mode), .done(done3), .busy(busy3),
      .a_addr(a_addr3), .w_addr(w_addr3), .mem_rd(mem_rd3),
      .mac_clr(mac_clr3), .mac_en(mac_en3), .r_sh_en(r_sh_en3),
      .act_relu(act_relu3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [9:0] v;
      repeat (2) @(posedge clk);
      #1;
      v = {done, busy, mem_rd, mac_clr, mac_en, r_sh_en, act_relu};
      checks++;
      if (v !== 10'b0) begin
         errors++;
         $display("FAIL reset_out got %b want %b", v, 10'b0);
      end
      checks++;
      if ({a_addr, w_addr} !== 32'h0000_0000) begin
         errors++;
         $display("FAIL reset_addr got %h want %h", {a_addr, w_addr}, 32'h0);
      end
      v = {done3, busy3, mem_rd3, mac_clr3, mac_en3, r_sh_en3, act_relu3};
      checks++;
      if (v !== 10'b0) begin
         errors++;
         $display("FAIL reset_out3 got %b want %b", v, 10'b0);
      end
      checks++;
      if ({a_addr3, w_addr3} !== 32'h0100_FFFC) begin
         errors++;
         $display("FAIL reset_addr3 got %h want %h",
                  {a_addr3, w_addr3}, 32'h0100_FFFC);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_run(input logic r);
      int g, p;
      logic [1:0] m, e_clr, e_en, e_sh;
      logic e_rd, e_busy, e_done;
      logic [9:0] ev, gv;
      logic [15:0] ea, ew;
      start = 1'b1;
      relu_mode = r;
      tick();
      start = 1'b0;
      for (int k = 0; k <= 21; k++) begin
         if (k == 10) relu_mode = ~r;
         g = k / 7;
         p = k % 7;
         m = (g < 2) ? 2'b11 : 2'b01;
         e_clr  = (k < 21 && p == 0) ? m : 2'b00;
         e_rd   = (k < 21 && p >= 1 && p <= 4);
         e_en   = (k < 21 && p >= 2 && p <= 5) ? m : 2'b00;
         e_sh   = (k < 21 && p == 6) ? m : 2'b00;
         e_busy = (k < 21);
         e_done = (k == 21);
         ev = {e_done, e_busy, e_rd, e_clr, e_en, e_sh, r};
         gv = {done, busy, mem_rd, mac_clr, mac_en, r_sh_en, act_relu};
         checks++;
         if (gv !== ev) begin
            errors++;
            $display("FAIL run k=%0d got %b want %b", k, gv, ev);
         end
         if (e_rd) begin
            ea = 16'(p - 1);
            ew = 16'(g * 4 + p - 1);
            checks++;
            if ({a_addr, w_addr} !== {ea, ew}) begin
               errors++;
               $display("FAIL run_addr k=%0d got %h want %h",
                        k, {a_addr, w_addr}, {ea, ew});
            end
         end
         if (k < 21) tick();
      end
      repeat (2) tick();
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL done_hold got %b want %b", {done, busy}, 2'b10);
      end
   endtask

   task automatic test_lat3;
      int g, p;
      logic [1:0] m, e_clr, e_en, e_sh;
      logic e_rd, e_busy, e_done;
      logic [9:0] ev, gv;
      logic [15:0] ea, ew;
      relu_mode = 1'b0;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int k = 0; k <= 27; k++) begin
         g = k / 9;
         p = k % 9;
         m = (g < 2) ? 2'b11 : 2'b01;
         e_clr  = (k < 27 && p == 0) ? m : 2'b00;
         e_rd   = (k < 27 && p >= 1 && p <= 4);
         e_en   = (k < 27 && p >= 4 && p <= 7) ? m : 2'b00;
         e_sh   = (k < 27 && p == 8) ? m : 2'b00;
         e_busy = (k < 27);
         e_done = (k == 27);
         ev = {e_done, e_busy, e_rd, e_clr, e_en, e_sh, 1'b0};
         gv = {done3, busy3, mem_rd3, mac_clr3, mac_en3, r_sh_en3,
               act_relu3};
         checks++;
         if (gv !== ev) begin
            errors++;
            $display("FAIL lat3 k=%0d got %b want %b", k, gv, ev);
         end
         if (e_rd) begin
            ea = 16'h0100 + 16'(p - 1);
            ew = 16'hFFFC + 16'(g * 4 + p - 1);
            checks++;
            if ({a_addr3, w_addr3} !== {ea, ew}) begin
               errors++;
               $display("FAIL lat3_addr k=%0d got %h want %h",
                        k, {a_addr3, w_addr3}, {ea, ew});
            end
         end
         if (k < 27) tick();
      end
   endtask

   task automatic test_relu_restart;
      logic [2:0] ev, gv;
      relu_mode = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({done, busy, act_relu, mac_clr} !== 5'b01011) begin
         errors++;
         $display("FAIL restart got %b want %b",
                  {done, busy, act_relu, mac_clr}, 5'b01011);
      end
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k == 8) begin
            start = 1'b1;
            relu_mode = 1'b1;
         end
         if (k == 9) start = 1'b0;
         ev = {(k == 21), (k < 21), 1'b0};
         gv = {done, busy, act_relu};
         checks++;
         if (gv !== ev) begin
            errors++;
            $display("FAIL busy_start k=%0d got %b want %b", k, gv, ev);
         end
         if (k == 20) begin
            checks++;
            if (r_sh_en !== 2'b01) begin
               errors++;
               $display("FAIL last_shift got %b want %b", r_sh_en, 2'b01);
            end
         end
      end
      relu_mode = 1'b0;
   endtask

   task automatic test_soft_reset;
      logic [8:0] v;
      relu_mode = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      checks++;
      if ({mem_rd, mac_en, a_addr, w_addr} !== {3'b111, 16'd1, 16'd5}) begin
         errors++;
         $display("FAIL g1_fetch got %b %h %h want 111 0001 0005",
                  {mem_rd, mac_en}, a_addr, w_addr);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int n = 0; n < 2; n++) begin
         v = {done, busy, mem_rd, mac_clr, mac_en, r_sh_en};
         checks++;
         if (v !== 9'b0) begin
            errors++;
            $display("FAIL soft_reset n=%0d got %b want %b", n, v, 9'b0);
         end
         tick();
      end
      checks++;
      if (done3 !== 1'b0) begin
         errors++;
         $display("FAIL soft_reset3 got %b want 0", done3);
      end
      start = 1'b1;
      relu_mode = 1'b0;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, mac_clr} !== 3'b111) begin
         errors++;
         $display("FAIL rerun_clr got %b want 111", {busy, mac_clr});
      end
      tick();
      checks++;
      if ({mem_rd, a_addr, w_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL rerun_addr got %b %h %h want 1 0000 0000",
                  mem_rd, a_addr, w_addr);
      end
      repeat (20) tick();
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL rerun_done got %b want 10", {done, busy});
      end
   endtask

   task automatic test_async_reset;
      logic [9:0] v;
      start = 1'b1;
      relu_mode = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      checks++;
      if ({mem_rd, mac_en} !== 3'b011) begin
         errors++;
         $display("FAIL drain got %b want 011", {mem_rd, mac_en});
      end
      #2;
      rst = 1'b0;
      #1;
      v = {done, busy, mem_rd, mac_clr, mac_en, r_sh_en, act_relu};
      checks++;
      if (v !== 10'b0 || {a_addr, w_addr} !== 32'h0) begin
         errors++;
         $display("FAIL async_rst got %b %h want %b 0", v,
                  {a_addr, w_addr}, 10'b0);
      end
      checks++;
      if ({a_addr3, w_addr3} !== 32'h0100_FFFC) begin
         errors++;
         $display("FAIL async_rst3 got %h want %h",
                  {a_addr3, w_addr3}, 32'h0100_FFFC);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_priority;
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      checks++;
      if ({done, busy, mac_clr} !== 4'b0) begin
         errors++;
         $display("FAIL prio got %b want 0000", {done, busy, mac_clr});
      end
      tick();
      checks++;
      if ({done, busy, mem_rd} !== 3'b0) begin
         errors++;
         $display("FAIL prio_idle got %b want 000", {done, busy, mem_rd});
      end
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      start3 = 1'b0;
      reset = 1'b0;
      relu_mode = 1'b0;
      test_reset();
      test_run(1'b1);
      test_lat3();
      test_relu_restart();
      test_soft_reset();
      test_async_reset();
      test_run(1'b1);
      test_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
